// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scanning controller for a ROWS x COLS key matrix.
// Drives one column at a time, samples the synchronized row lines into a
// full-matrix image, debounces that image across consecutive scans, and
// reports a single debounced key press on a valid/ready interface.
module keypad_scan_ctrl #(
    parameter int  ROWS     = 4,
    parameter int  COLS     = 4,
    parameter int  SETTLE   = 3,
    parameter int  DEBOUNCE = 3,
    localparam int KW       = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_drive,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    input  logic            key_ready,
    output logic            key_held,
    output logic            multi_key,
    output logic            overflow,
    input  logic            clr_ovf
);

    localparam int IMG = ROWS * COLS;
    localparam int CW  = $clog2(COLS);
    localparam int SW  = $clog2(SETTLE + 1);
    localparam int DW  = $clog2(DEBOUNCE + 1);
    localparam int NW  = $clog2(IMG + 1);

    // The 2FF synchronizer must have fully propagated before a column is sampled.
    generate
        if (SETTLE < 3) begin : g_bad_settle
            $error("keypad_scan_ctrl: SETTLE must be >= 3");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EVAL
    } state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] sync1_q, sync2_q;
    logic [CW-1:0]   col_q, col_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [IMG-1:0]  image_q, image_d;
    logic [IMG-1:0]  prev_q, prev_d;
    logic [DW-1:0]   stable_q, stable_d;
    logic            held_q, held_d;
    logic            multi_q, multi_d;
    logic            valid_q, valid_d;
    logic [KW-1:0]   code_q, code_d;
    logic            ovf_q, ovf_d;

    // Debounce / event helpers
    logic [NW-1:0]   ones;
    logic [KW-1:0]   single_code;
    logic            same;
    logic [DW-1:0]   stable_new;
    logic            act;
    logic            ev;
    logic            fire;
    logic            drop;

    // Two-stage synchronizer on the raw row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
        end
    end

    // Scan FSM and datapath state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            settle_q <= '0;
            image_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            held_q   <= 1'b0;
            multi_q  <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            settle_q <= settle_d;
            image_q  <= image_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            held_q   <= held_d;
            multi_q  <= multi_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            ovf_q    <= ovf_d;
        end
    end

    // Population count of the image and the key code of its (last) set bit.
    // Image bits are column-major; key codes are row*COLS + col.
    always_comb begin
        ones        = '0;
        single_code = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (image_q[c*ROWS + r]) begin
                    ones        = ones + NW'(1);
                    single_code = KW'(r * COLS + c);
                end
            end
        end
    end

    // Debounce counter step: act only on the scan where the count reaches DEBOUNCE.
    always_comb begin
        same = (image_q == prev_q);
        if (!same) begin
            stable_new = DW'(1);
        end else if (stable_q == DW'(DEBOUNCE)) begin
            stable_new = stable_q;
        end else begin
            stable_new = stable_q + DW'(1);
        end
        act = (stable_new == DW'(DEBOUNCE)) && (!same || (stable_q != DW'(DEBOUNCE)));
    end

    // Next-state logic: scan sequencing, image capture and debounce decisions.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        settle_d = settle_q;
        image_d  = image_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        held_d   = held_q;
        multi_d  = multi_q;
        ev       = 1'b0;
        if (!enable) begin
            // Abandon the scan in progress; reported state is kept.
            state_d  = S_IDLE;
            col_d    = '0;
            settle_d = '0;
            stable_d = '0;
            image_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_DRIVE;
                    col_d    = '0;
                    settle_d = '0;
                end
                S_DRIVE: begin
                    if (settle_q == SW'(SETTLE - 1)) begin
                        settle_d = '0;
                        state_d  = S_SAMPLE;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                S_SAMPLE: begin
                    image_d[col_q*ROWS +: ROWS] = sync2_q;
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = S_EVAL;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = S_DRIVE;
                    end
                end
                S_EVAL: begin
                    stable_d = stable_new;
                    if (!same) begin
                        prev_d = image_q;
                    end
                    if (act) begin
                        if (ones == NW'(0)) begin
                            held_d  = 1'b0;
                            multi_d = 1'b0;
                        end else if (ones > NW'(1)) begin
                            multi_d = 1'b1;
                        end else if (!held_q) begin
                            held_d  = 1'b1;
                            multi_d = 1'b0;
                            ev      = 1'b1;
                        end
                    end
                    image_d = '0;
                    col_d   = '0;
                    state_d = S_DRIVE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Event slot: a handshake frees the slot in the same cycle a new event may load.
    always_comb begin
        fire    = valid_q && key_ready;
        drop    = ev && valid_q && !key_ready;
        valid_d = valid_q;
        code_d  = code_q;
        if (ev) begin
            valid_d = 1'b1;
            if (!drop) begin
                code_d = single_code;
            end
        end else if (fire) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // One-hot column drive during DRIVE and SAMPLE only.
    always_comb begin
        col_drive = '0;
        if ((state_q == S_DRIVE) || (state_q == S_SAMPLE)) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_q == CW'(c)) begin
                    col_drive[c] = 1'b1;
                end
            end
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = held_q;
    assign multi_key = multi_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: scan-level reference model of the keypad controller.
// Keys are held constant for each whole scan; the model applies the debounce
// rules once per scan and predicts the reported outputs.
module tb_keypad_scan_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SETTLE   = 3;
    localparam int DEBOUNCE = 3;
    localparam int KW       = $clog2(ROWS * COLS);
    localparam int IMG      = ROWS * COLS;
    localparam int PERIOD   = COLS * (SETTLE + 1) + 1;
    localparam int MID      = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_drive;
    logic            key_valid;
    logic [KW-1:0]   key_code;
    logic            key_ready;
    logic            key_held;
    logic            multi_key;
    logic            overflow;
    logic            clr_ovf;

    logic [IMG-1:0]  keys_v;   // bit index = row*COLS + col

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit             m_valid, m_held, m_multi, m_ovf;
    int             m_code;
    logic [IMG-1:0] m_last;
    int             m_run;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .row_in(row_in),
        .col_drive(col_drive), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .key_held(key_held), .multi_key(multi_key),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its column drive onto its row line.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (col_drive[c] && keys_v[r*COLS + c]) row_in[r] = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_held = 0; m_multi = 0; m_ovf = 0;
        m_code = 0; m_last = '0; m_run = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, 32'(key_valid), 32'(m_valid));
        check_eq({tag, ".code"},  32'(key_code),  32'(m_code));
        check_eq({tag, ".held"},  32'(key_held),  32'(m_held));
        check_eq({tag, ".multi"}, 32'(multi_key), 32'(m_multi));
        check_eq({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    endtask

    // Index of the lowest set bit (only used on single-bit patterns).
    function automatic int bit_index(input logic [IMG-1:0] p);
        bit_index = 0;
        for (int i = IMG - 1; i >= 0; i--) if (p[i]) bit_index = i;
    endfunction

    // One full scan with a constant key pattern. rdy/clr: 0 none, 1 mid-scan, 2 on the EVAL cycle.
    // Entered and left at #1 after the edge that starts DRIVE of column 0.
    task automatic run_scan(input logic [IMG-1:0] pat, input int rdy, input int clr);
        bit ev, drop;
        int n;
        keys_v = pat;
        for (int k = 0; k < PERIOD; k++) begin
            check_eq("col_drive", 32'(col_drive),
                     (k == PERIOD - 1) ? 32'd0 : (32'd1 << (k / (SETTLE + 1))));
            key_ready = ((rdy == 1) && (k == MID)) || ((rdy == 2) && (k == PERIOD - 1));
            clr_ovf   = ((clr == 1) && (k == MID)) || ((clr == 2) && (k == PERIOD - 1));
            @(posedge clk);
            #1;
            key_ready = 1'b0;
            clr_ovf   = 1'b0;
            if (k == MID) begin
                if (rdy == 1) m_valid = 0;
                if (clr == 1) m_ovf = 0;
                check_eq("mid.valid", 32'(key_valid), 32'(m_valid));
                check_eq("mid.ovf",   32'(overflow),  32'(m_ovf));
            end
        end
        // Debounce decision for this scan
        ev = 0;
        if (pat == m_last) m_run++;
        else begin
            m_run  = 1;
            m_last = pat;
        end
        if (m_run == DEBOUNCE) begin
            n = $countones(pat);
            if (n == 0) begin
                m_held = 0; m_multi = 0;
            end else if (n > 1) begin
                m_multi = 1;
            end else if (!m_held) begin
                m_held = 1; m_multi = 0; ev = 1;
            end
        end
        // Event slot delivery
        drop = 0;
        if (ev) begin
            if (!m_valid || rdy == 2) begin
                m_valid = 1;
                m_code  = bit_index(pat);
            end else begin
                drop = 1;
            end
        end else if (rdy == 2) begin
            m_valid = 0;
        end
        if (drop) m_ovf = 1;
        else if (clr == 2) m_ovf = 0;
        check_outputs("scan");
        $display("scan keys=%04h rdy=%0d clr=%0d -> valid=%0d code=%0d held=%0d multi=%0d ovf=%0d",
                 pat, rdy, clr, key_valid, key_code, key_held, multi_key, overflow);
    endtask

    task automatic repeat_scan(input logic [IMG-1:0] pat, input int times, input int rdy);
        for (int i = 0; i < times; i++) run_scan(pat, rdy, 0);
    endtask

    initial begin
        logic [IMG-1:0] pat;
        int reps;
        rst = 1'b1; enable = 1'b0; key_ready = 1'b0; clr_ovf = 1'b0; keys_v = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("reset");
        check_eq("reset.col_drive", 32'(col_drive), 32'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;

        // Single key row2/col1 -> code 9
        repeat_scan(16'h0200, 4, 0);
        run_scan(16'h0000, 1, 0);
        repeat_scan(16'h0000, 3, 0);
        // One-scan glitch is ignored
        run_scan(16'h0200, 0, 0);
        repeat_scan(16'h0000, 3, 0);
        // Two keys in column 0 -> multi_key, no event
        repeat_scan(16'h0011, 3, 0);
        repeat_scan(16'h0000, 3, 0);
        // Overflow: code 5 then code 6 with no consumer
        repeat_scan(16'h0020, 3, 0);
        repeat_scan(16'h0000, 3, 0);
        repeat_scan(16'h0040, 3, 0);
        repeat_scan(16'h0000, 3, 0);
        run_scan(16'h0000, 1, 0);
        run_scan(16'h0000, 0, 1);
        // Held key reports once; new press after release
        repeat_scan(16'h0020, 10, 0);
        run_scan(16'h0020, 1, 0);
        repeat_scan(16'h0000, 3, 0);
        repeat_scan(16'h0020, 3, 0);
        // Handshake and new event in the same cycle; drop together with clear
        repeat_scan(16'h0000, 3, 0);
        repeat_scan(16'h0008, 2, 0);
        run_scan(16'h0008, 2, 0);
        repeat_scan(16'h0000, 3, 0);
        repeat_scan(16'h0004, 2, 0);
        run_scan(16'h0004, 0, 2);

        // Randomized key patterns, consumer behaviour and overflow clears
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       pat = '0;
                1, 2:    pat = IMG'(1) << $urandom_range(0, IMG - 1);
                default: pat = (IMG'(1) << $urandom_range(0, IMG - 1)) |
                               (IMG'(1) << $urandom_range(0, IMG - 1));
            endcase
            reps = $urandom_range(1, 4);
            for (int j = 0; j < reps; j++)
                run_scan(pat, $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? 1 : 0);
        end

        // enable dropped in the middle of DRIVE
        keys_v = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        check_eq("idle.col_drive", 32'(col_drive), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle.col_drive2", 32'(col_drive), 32'd0);
        m_run = 0;
        check_outputs("idle");
        enable = 1'b1;
        @(posedge clk); #1;
        repeat_scan(16'h0000, 3, 1);
        repeat_scan(16'h0008, 3, 0);
        check_eq("pre_rst.valid", 32'(key_valid), 32'd1);

        // Asynchronous reset in the middle of a scan with an event pending
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check_eq("async_rst.col_drive", 32'(col_drive), 32'd0);
        keys_v = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        repeat_scan(16'h0100, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
